pc_sequencer: RTL and testbench

Parametrised next-generation program counter for the RISC datapath.
- Extends increment/branch/load behaviour with an opcode-driven next-PC select.
- Adds configurable width, step size and reset vector.
- Adds a hardware return-address stack (RAS) for call/return.
- Sits between control unit and instruction memory address port; newPC feeds memory and the datapath PC register.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/return_addr_stack.sv | 55 +++++
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   pc_op_t     3-bit next-PC operation select
//   PC_OP_*     operation encodings; 6 and 7 are reserved and act as HOLD
package pc_seq_pkg;

  typedef logic [2:0] pc_op_t;

  localparam pc_op_t PC_OP_HOLD   = 3'd0;
  localparam pc_op_t PC_OP_INC    = 3'd1;
  localparam pc_op_t PC_OP_BRANCH = 3'd2;
  localparam pc_op_t PC_OP_JUMP   = 3'd3;
  localparam pc_op_t PC_OP_CALL   = 3'd4;
  localparam pc_op_t PC_OP_RET    = 3'd5;

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular LIFO of return addresses.
// A push while full overwrites the oldest entry, so the newest DEPTH
// entries always pop back in order. A pop while empty is ignored.
// Ports:
//   clock      rising-edge clock
//   clear      synchronous active-high reset (pointer and count only)
//   push       write push_data on top of the stack
//   pop        remove the top entry
//   push_data  address to push
//   top_data   current top entry (valid when count != 0)
//   count      number of valid entries, saturates at DEPTH
module return_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] sp_p0;   // next free slot; wraps because DEPTH is a power of two
  logic [CNT_W-1:0] cnt_p0;

  assign top_data = mem[sp_p0 - PTR_W'(1)];
  assign count    = cnt_p0;

  always_ff @(posedge clock) begin
    if (clear) begin
      sp_p0  <= '0;
      cnt_p0 <= '0;
    end else if (push) begin
      sp_p0 <= sp_p0 + PTR_W'(1);
      if (cnt_p0 != CNT_W'(DEPTH))
        cnt_p0 <= cnt_p0 + CNT_W'(1);
    end else if (pop && (cnt_p0 != '0)) begin
      sp_p0  <= sp_p0 - PTR_W'(1);
      cnt_p0 <= cnt_p0 - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear)
      mem[sp_p0] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: opcode-driven next-PC generator with a return-address stack.
// Optional interrupt entry is compiled in with `define PC_SEQ_IRQ_EN.
// Ports:
//   clock, clear        rising-edge clock, synchronous active-high reset
//   enable              advance strobe; low holds all state
//   pc_op               HOLD/INC/BRANCH/JUMP/CALL/RET (6,7 = HOLD)
//   CON                 branch condition
//   target              absolute JUMP/CALL address
//   offset              sign-extended BRANCH offset
//   newPC               registered current PC
//   ras_count/full/empty  return-stack occupancy
//   ras_overflow        sticky: CALL (or irq) while full
//   ras_underflow       sticky: RET while empty
//   irq, irq_ack        (PC_SEQ_IRQ_EN only) interrupt request / registered ack
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  STEP         = 1,
  parameter int                  RAS_DEPTH    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
`ifdef PC_SEQ_IRQ_EN
  parameter logic [31:0]         IRQ_VECTOR   = 32'h0000_0100,
`endif
  localparam int CNT_W = $clog2(RAS_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                enable,
  input  pc_op_t              pc_op,
  input  logic                CON,
  input  logic [PC_WIDTH-1:0] target,
  input  logic [PC_WIDTH-1:0] offset,
`ifdef PC_SEQ_IRQ_EN
  input  logic                irq,
  output logic                irq_ack,
`endif
  output logic [PC_WIDTH-1:0] newPC,
  output logic [CNT_W-1:0]    ras_count,
  output logic                ras_full,
  output logic                ras_empty,
  output logic                ras_overflow,
  output logic                ras_underflow
);

  logic [PC_WIDTH-1:0]        pc_p0;
  logic                       ovf_p0;
  logic                       unf_p0;
  logic signed [PC_WIDTH-1:0] offset_s;
  logic [PC_WIDTH-1:0]        pc_inc;
  logic [PC_WIDTH-1:0]        pc_br;
  logic [PC_WIDTH-1:0]        pc_next;
  logic [PC_WIDTH-1:0]        push_data;
  logic [PC_WIDTH-1:0]        ras_top;
  logic                       push;
  logic                       pop;
  logic                       set_ovf;
  logic                       set_unf;
`ifdef PC_SEQ_IRQ_EN
  logic                       irq_take;
  logic                       irq_ack_p0;
`endif

  assign offset_s = signed'(offset);
  assign pc_inc   = pc_p0 + PC_WIDTH'(STEP);
  assign pc_br    = PC_WIDTH'(signed'(pc_p0) + offset_s);

  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  always_comb begin
    pc_next   = pc_p0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    irq_take  = 1'b0;
`endif
    if (enable) begin
`ifdef PC_SEQ_IRQ_EN
      // The interrupted instruction has not run yet, so its own PC is saved.
      if (irq) begin
        irq_take  = 1'b1;
        push      = 1'b1;
        push_data = pc_p0;
        pc_next   = PC_WIDTH'(IRQ_VECTOR);
        set_ovf   = ras_full;
      end else
`endif
      begin
        case (pc_op)
          PC_OP_INC:    pc_next = pc_inc;
          PC_OP_BRANCH: pc_next = CON ? pc_br : pc_inc;
          PC_OP_JUMP:   pc_next = target;
          PC_OP_CALL: begin
            push    = 1'b1;
            pc_next = target;
            set_ovf = ras_full;
          end
          PC_OP_RET: begin
            if (ras_empty) begin
              pc_next = pc_inc;
              set_unf = 1'b1;
            end else begin
              pop     = 1'b1;
              pc_next = ras_top;
            end
          end
          default: pc_next = pc_p0;
        endcase
      end
    end
  end

  // ---- register stage: PC and sticky flags ----
  always_ff @(posedge clock) begin
    if (clear) begin
      pc_p0  <= RESET_VECTOR;
      ovf_p0 <= 1'b0;
      unf_p0 <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
      irq_ack_p0 <= 1'b0;
`endif
    end else begin
      pc_p0  <= pc_next;
      ovf_p0 <= ovf_p0 | set_ovf;
      unf_p0 <= unf_p0 | set_unf;
`ifdef PC_SEQ_IRQ_EN
      irq_ack_p0 <= irq_take;
`endif
    end
  end

  assign newPC         = pc_p0;
  assign ras_overflow  = ovf_p0;
  assign ras_underflow = unf_p0;
`ifdef PC_SEQ_IRQ_EN
  assign irq_ack = irq_ack_p0;
`endif

  return_addr_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top_data  (ras_top),
    .count     (ras_count)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a
// queue-based reference model (default parameters: 32-bit, STEP 1, depth 8).
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        enable = 1'b0;
  pc_op_t      pc_op = PC_OP_HOLD;
  logic        CON = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] offset = '0;
  logic [31:0] newPC;
  logic [3:0]  ras_count;
  logic        ras_full, ras_empty, ras_overflow, ras_underflow;
`ifdef PC_SEQ_IRQ_EN
  logic        irq = 1'b0;
  logic        irq_ack;
  logic        m_ack;
`endif

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_ovf, m_unf;

  int n_cmp = 0;
  int n_fail = 0;

  pc_sequencer dut (
    .clock         (clock),
    .clear         (clear),
    .enable        (enable),
    .pc_op         (pc_op),
    .CON           (CON),
    .target        (target),
    .offset        (offset),
`ifdef PC_SEQ_IRQ_EN
    .irq           (irq),
    .irq_ack       (irq_ack),
`endif
    .newPC         (newPC),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, wait past the edge, then advance the model.
  task automatic apply(input logic c, input logic en, input logic [2:0] op,
                       input logic cn, input logic [31:0] tg, input logic [31:0] of);
    clear = c; enable = en; pc_op = op; CON = cn; target = tg; offset = of;
    @(posedge clock); #1;
`ifdef PC_SEQ_IRQ_EN
    m_ack = 1'b0;
`endif
    if (c) begin
      m_pc = 32'h0; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (en) begin
`ifdef PC_SEQ_IRQ_EN
      if (irq) begin
        if (m_ras.size() == 8) begin void'(m_ras.pop_front()); m_ovf = 1'b1; end
        m_ras.push_back(m_pc);
        m_pc = 32'h100;
        m_ack = 1'b1;
      end else
`endif
      case (op)
        3'd1: m_pc = m_pc + 1;
        3'd2: m_pc = cn ? m_pc + of : m_pc + 1;
        3'd3: m_pc = tg;
        3'd4: begin
          if (m_ras.size() == 8) begin void'(m_ras.pop_front()); m_ovf = 1'b1; end
          m_ras.push_back(m_pc + 1);
          m_pc = tg;
        end
        3'd5: begin
          if (m_ras.size() == 0) begin m_pc = m_pc + 1; m_unf = 1'b1; end
          else m_pc = m_ras.pop_back();
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) apply(1, 1, PC_OP_INC, 0, 0, 0);
    n_cmp++;
    if (newPC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", newPC); end
    n_cmp++;
    if (ras_empty !== 1'b1 || ras_count !== 4'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_ras: empty=%b count=%0d ovf=%b unf=%b want 1/0/0/0",
                          ras_empty, ras_count, ras_overflow, ras_underflow);
    end
    apply(0, 0, PC_OP_INC, 0, 0, 0);
    n_cmp++;
    if (newPC !== 32'h0) begin n_fail++; $display("FAIL hold_disabled: got %h want 0", newPC); end
  endtask

  task automatic test_inc_branch;
    for (int i = 0; i < 4; i++) apply(0, 1, PC_OP_INC, 0, 0, 0);
    n_cmp++;
    if (newPC !== 32'd4) begin n_fail++; $display("FAIL inc4: got %h want 4", newPC); end
    apply(0, 1, PC_OP_BRANCH, 1, 0, 32'hFFFF_FFFE);
    n_cmp++;
    if (newPC !== 32'd2) begin n_fail++; $display("FAIL branch_taken: got %h want 2", newPC); end
    apply(0, 1, PC_OP_BRANCH, 0, 0, 32'hFFFF_FFFE);
    n_cmp++;
    if (newPC !== 32'd3) begin n_fail++; $display("FAIL branch_not_taken: got %h want 3", newPC); end
    apply(0, 1, 3'd6, 1, 32'h55, 32'h7);
    n_cmp++;
    if (newPC !== 32'd3) begin n_fail++; $display("FAIL reserved_op: got %h want 3", newPC); end
  endtask

  task automatic test_call_ret;
    apply(0, 1, PC_OP_CALL, 0, 32'h40, 0);
    n_cmp++;
    if (newPC !== 32'h40) begin n_fail++; $display("FAIL call1: got %h want 40", newPC); end
    apply(0, 1, PC_OP_CALL, 0, 32'h80, 0);
    n_cmp++;
    if (newPC !== 32'h80 || ras_count !== 4'd2) begin
      n_fail++; $display("FAIL call2: pc=%h count=%0d want 80/2", newPC, ras_count);
    end
    apply(0, 1, PC_OP_RET, 0, 0, 0);
    n_cmp++;
    if (newPC !== 32'h41) begin n_fail++; $display("FAIL ret1: got %h want 41", newPC); end
    apply(0, 1, PC_OP_RET, 0, 0, 0);
    n_cmp++;
    if (newPC !== 32'h4 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL ret2: pc=%h empty=%b want 4/1", newPC, ras_empty);
    end
  endtask

  task automatic test_overflow;
    apply(1, 0, PC_OP_HOLD, 0, 0, 0);
    for (int i = 0; i < 9; i++) apply(0, 1, PC_OP_CALL, 0, i + 1, 0);
    n_cmp++;
    if (ras_overflow !== 1'b1 || ras_count !== 4'd8 || ras_full !== 1'b1) begin
      n_fail++; $display("FAIL overflow_flags: ovf=%b count=%0d full=%b want 1/8/1",
                          ras_overflow, ras_count, ras_full);
    end
    for (int k = 0; k < 8; k++) begin
      apply(0, 1, PC_OP_RET, 0, 0, 0);
      n_cmp++;
      if (newPC !== 32'(9 - k)) begin
        n_fail++; $display("FAIL overflow_ret%0d: got %h want %h", k, newPC, 32'(9 - k));
      end
    end
    n_cmp++;
    if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow_drain: empty=%b unf=%b want 1/0", ras_empty, ras_underflow);
    end
  endtask

  task automatic test_underflow_wrap;
    apply(0, 1, PC_OP_JUMP, 0, 32'h10, 0);
    apply(0, 1, PC_OP_RET, 0, 0, 0);
    n_cmp++;
    if (newPC !== 32'h11 || ras_underflow !== 1'b1 || ras_count !== 4'd0) begin
      n_fail++; $display("FAIL underflow: pc=%h unf=%b count=%0d want 11/1/0",
                          newPC, ras_underflow, ras_count);
    end
    apply(0, 1, PC_OP_JUMP, 0, 32'hFFFF_FFFF, 0);
    apply(0, 1, PC_OP_INC, 0, 0, 0);
    n_cmp++;
    if (newPC !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h want 0", newPC); end
    n_cmp++;
    if (ras_underflow !== 1'b1 || ras_overflow !== 1'b1) begin
      n_fail++; $display("FAIL sticky: unf=%b ovf=%b want 1/1", ras_underflow, ras_overflow);
    end
  endtask

  task automatic test_clear_mid_call;
    apply(0, 1, PC_OP_CALL, 0, 32'h200, 0);
    apply(1, 1, PC_OP_CALL, 0, 32'h300, 0);
    n_cmp++;
    if (newPC !== 32'h0 || ras_count !== 4'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      n_fail++; $display("FAIL clear_mid_call: pc=%h count=%0d ovf=%b unf=%b want 0/0/0/0",
                          newPC, ras_count, ras_overflow, ras_underflow);
    end
  endtask

`ifdef PC_SEQ_IRQ_EN
  task automatic test_irq;
    apply(0, 1, PC_OP_JUMP, 0, 32'h20, 0);
    irq = 1'b1;
    apply(0, 1, PC_OP_INC, 0, 0, 0);
    irq = 1'b0;
    n_cmp++;
    if (newPC !== 32'h100 || irq_ack !== 1'b1) begin
      n_fail++; $display("FAIL irq_entry: pc=%h ack=%b want 100/1", newPC, irq_ack);
    end
    apply(0, 1, PC_OP_HOLD, 0, 0, 0);
    n_cmp++;
    if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_ack_pulse: got %b want 0", irq_ack); end
    apply(0, 1, PC_OP_RET, 0, 0, 0);
    n_cmp++;
    if (newPC !== 32'h20) begin n_fail++; $display("FAIL irq_ret: got %h want 20", newPC); end
  endtask
`endif

  task automatic test_random;
    logic [2:0] op;
    logic       c, en;
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      c  = ($urandom_range(0, 99) < 3);
      en = ($urandom_range(0, 99) < 85);
`ifdef PC_SEQ_IRQ_EN
      irq = ($urandom_range(0, 99) < 5);
`endif
      apply(c, en, op, 1'($urandom), $urandom, 32'($signed($urandom_range(0, 64)) - 32));
      n_cmp++;
      if (newPC !== m_pc) begin
        n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, newPC, m_pc);
      end
      n_cmp++;
      if (ras_count !== 4'(m_ras.size()) || ras_full !== (m_ras.size() == 8) ||
          ras_empty !== (m_ras.size() == 0)) begin
        n_fail++; $display("FAIL rand_ras[%0d]: count=%0d full=%b empty=%b want count %0d",
                            i, ras_count, ras_full, ras_empty, m_ras.size());
      end
      n_cmp++;
      if (ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
        n_fail++; $display("FAIL rand_flags[%0d]: ovf=%b unf=%b want %b/%b",
                            i, ras_overflow, ras_underflow, m_ovf, m_unf);
      end
`ifdef PC_SEQ_IRQ_EN
      n_cmp++;
      if (irq_ack !== m_ack) begin
        n_fail++; $display("FAIL rand_ack[%0d]: got %b want %b", i, irq_ack, m_ack);
      end
`endif
    end
`ifdef PC_SEQ_IRQ_EN
    irq = 1'b0;
`endif
  endtask

  initial begin
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    m_ack = 1'b0;
`endif
    test_reset();
    test_inc_branch();
    test_call_ret();
    test_overflow();
    test_underflow_wrap();
    test_clear_mid_call();
`ifdef PC_SEQ_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
